// File: rtl/dds_freq_meter_pkg.sv
// Constants shared with the DDS block and the frequency meter state encoding.
package dds_freq_meter_pkg;

    localparam int unsigned MIDSCALE    = 128;
    localparam int unsigned PHASE_BITS  = 16;
    localparam int unsigned SAMPLE_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_COUNT,
        ST_DIV,
        ST_DONE
    } meter_state_t;

endpackage

// File: rtl/dds_freq_meter_serial_divider.sv
// Restoring serial divider: one quotient bit per clock, Done_o pulses NUM_WIDTH cycles after Start_i.
module serial_divider #(
    parameter int NUM_WIDTH = 19,
    parameter int DEN_WIDTH = 20
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Start_i,
    input  logic [NUM_WIDTH+DEN_WIDTH-1:0] Num_i,
    input  logic [DEN_WIDTH-1:0]           Den_i,
    output logic [NUM_WIDTH-1:0]           Quotient_o,
    output logic                           Done_o
);

    localparam int unsigned CW = $clog2(NUM_WIDTH + 1);

    logic [DEN_WIDTH-1:0] rem;
    logic [DEN_WIDTH-1:0] den;
    logic [NUM_WIDTH-1:0] quo;
    logic [CW-1:0]        left;
    logic [DEN_WIDTH:0]   trial;
    logic                 take;

    always_comb begin
        trial = {rem, quo[NUM_WIDTH-1]};
        take  = (trial >= {1'b0, den});
    end

    // Upper DEN_WIDTH numerator bits preload the remainder; caller guarantees they are below Den_i
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rem    <= '0;
            den    <= '0;
            quo    <= '0;
            left   <= '0;
            Done_o <= 1'b0;
        end else begin
            Done_o <= 1'b0;
            if (Start_i) begin
                rem  <= Num_i[NUM_WIDTH+DEN_WIDTH-1:NUM_WIDTH];
                quo  <= Num_i[NUM_WIDTH-1:0];
                den  <= Den_i;
                left <= CW'(NUM_WIDTH);
            end else if (left != '0) begin
                rem  <= take ? DEN_WIDTH'(trial - {1'b0, den}) : trial[DEN_WIDTH-1:0];
                quo  <= {quo[NUM_WIDTH-2:0], take};
                left <= left - CW'(1);
                if (left == CW'(1))
                    Done_o <= 1'b1;
            end
        end
    end

    assign Quotient_o = quo;

endmodule

// File: rtl/dds_freq_meter.sv
// Measures sine frequency via hysteretic midscale crossings and reports the equivalent DDS tuning word.
module dds_freq_meter
    import dds_freq_meter_pkg::*;
#(
    parameter int PERIODS_LOG2 = 2,
    parameter int HYST         = 8,
    parameter int CNT_WIDTH    = 20
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start_i,
    input  logic [SAMPLE_BITS-1:0] Sample_i,
    output logic                   Busy_o,
    output logic                   Valid_o,
    output logic                   Timeout_o,
    output logic [7:0]             TuningWord_o,
    output logic [CNT_WIDTH-1:0]   Period_o
);

    localparam int unsigned QW   = PHASE_BITS + 1 + PERIODS_LOG2;
    localparam int unsigned NUMW = QW + CNT_WIDTH;
    localparam int unsigned EVW  = PERIODS_LOG2 + 1;
    localparam logic [SAMPLE_BITS-1:0] LO_TH   = SAMPLE_BITS'(MIDSCALE - HYST);
    localparam logic [SAMPLE_BITS-1:0] HI_TH   = SAMPLE_BITS'(MIDSCALE + HYST);
    localparam logic [EVW-1:0]         EV_LAST = EVW'((1 << PERIODS_LOG2) - 1);
    localparam logic [NUMW-1:0]        NUM_BASE = NUMW'(1) << (PHASE_BITS + PERIODS_LOG2);

    meter_state_t state, state_n;

    logic [SAMPLE_BITS-1:0] sample_reg;
    logic                   armed;
    logic                   evt;
    logic [CNT_WIDTH-1:0]   counter;
    logic [EVW-1:0]         event_cnt;
    logic [CNT_WIDTH-1:0]   n_reg;
    logic                   cnt_max;
    logic                   start_acc;
    logic                   div_start;
    logic                   div_done;
    logic [QW-1:0]          quotient;
    logic [NUMW-1:0]        numerator;

    assign evt       = armed && (sample_reg >= HI_TH);
    assign cnt_max   = &counter;
    assign start_acc = (state == ST_IDLE) && Start_i;
    // Adding N/2 before the divide rounds the tuning word to nearest
    assign numerator = NUM_BASE + NUMW'(counter >> 1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        div_start = 1'b0;
        Busy_o    = 1'b0;
        Valid_o   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Start_i)
                    state_n = ST_SYNC;
            end
            ST_SYNC: begin
                Busy_o = 1'b1;
                if (cnt_max)
                    state_n = ST_IDLE;
                else if (evt)
                    state_n = ST_COUNT;
            end
            ST_COUNT: begin
                Busy_o = 1'b1;
                if (cnt_max)
                    state_n = ST_IDLE;
                else if (evt && (event_cnt == EV_LAST)) begin
                    state_n   = ST_DIV;
                    div_start = 1'b1;
                end
            end
            ST_DIV: begin
                Busy_o = 1'b1;
                if (div_done)
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                Valid_o = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sample_reg   <= '0;
            armed        <= 1'b0;
            counter      <= '0;
            event_cnt    <= '0;
            n_reg        <= '0;
            Timeout_o    <= 1'b0;
            TuningWord_o <= '0;
            Period_o     <= '0;
        end else begin
            sample_reg <= Sample_i;

            if (start_acc || evt)
                armed <= 1'b0;
            else if (sample_reg <= LO_TH)
                armed <= 1'b1;

            if (start_acc) begin
                counter   <= '0;
                Timeout_o <= 1'b0;
            end else if ((state == ST_SYNC) && evt && !cnt_max) begin
                counter   <= CNT_WIDTH'(1);
                event_cnt <= '0;
            end else if ((state == ST_SYNC) || (state == ST_COUNT)) begin
                counter <= counter + CNT_WIDTH'(1);
                if (cnt_max)
                    Timeout_o <= 1'b1;
                else if ((state == ST_COUNT) && evt)
                    event_cnt <= event_cnt + EVW'(1);
            end

            if (div_start)
                n_reg <= counter;

            if ((state == ST_DIV) && div_done) begin
                TuningWord_o <= (quotient[QW-1:8] != '0) ? 8'hFF : quotient[7:0];
                Period_o     <= n_reg;
            end
        end
    end

    serial_divider #(
        .NUM_WIDTH (QW),
        .DEN_WIDTH (CNT_WIDTH)
    ) u_div (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start_i    (div_start),
        .Num_i      (numerator),
        .Den_i      (counter),
        .Quotient_o (quotient),
        .Done_o     (div_done)
    );

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter driven by a behavioural DDS and synthetic sample patterns.
module tb_dds_freq_meter;

    localparam int CNT_W = 14;
    localparam int M_CONST = 0, M_DDS = 1, M_MAN = 2, M_DITHER = 3;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             Start_i;
    logic [7:0]       Sample_i;
    logic             Busy_o;
    logic             Valid_o;
    logic             Timeout_o;
    logic [7:0]       TuningWord_o;
    logic [CNT_W-1:0] Period_o;

    int          nerr = 0;
    int          nchecks = 0;
    int          vcount = 0;
    int          mode = M_CONST;
    logic [15:0] phase = '0;
    logic [15:0] tw = '0;
    logic [7:0]  man_seq [0:10];
    int          man_idx = 0;

    dds_freq_meter #(
        .PERIODS_LOG2 (2),
        .HYST         (8),
        .CNT_WIDTH    (CNT_W)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start_i      (Start_i),
        .Sample_i     (Sample_i),
        .Busy_o       (Busy_o),
        .Valid_o      (Valid_o),
        .Timeout_o    (Timeout_o),
        .TuningWord_o (TuningWord_o),
        .Period_o     (Period_o)
    );

    always #5 Clock = ~Clock;

    // Sample source: the only driver of Sample_i, updated on the falling edge
    always @(negedge Clock) begin
        real ang;
        int  s;
        case (mode)
            M_DDS: begin
                ang = 2.0 * 3.14159265358979 * real'(phase) / 65536.0;
                s = 128 + int'(127.0 * $sin(ang));
                Sample_i = 8'(s);
                phase = phase + tw;
            end
            M_MAN: begin
                Sample_i = man_seq[man_idx];
                if (man_idx < 10)
                    man_idx++;
            end
            M_DITHER: Sample_i = 8'(121 + $urandom_range(14, 0));
            default:  Sample_i = 8'd128;
        endcase
    end

    always @(negedge Clock)
        if (Valid_o)
            vcount++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        Start_i = 1'b1;
        @(negedge Clock);
        Start_i = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output logic got);
        got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge Clock);
            if (Valid_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_dds(input logic [15:0] w, input logic [15:0] ph);
        @(posedge Clock);
        mode  = M_DDS;
        tw    = w;
        phase = ph;
    endtask

    initial begin
        logic got;
        int   lat;
        int   v0;

        for (int i = 0; i < 10; i++)
            man_seq[i] = (i % 2 == 0) ? 8'd0 : 8'd255;
        man_seq[10] = 8'd128;

        Reset   = 1'b0;
        Start_i = 1'b0;
        repeat (3) @(negedge Clock);
        check_eq("rst_busy", 32'(Busy_o), 0);
        check_eq("rst_valid", 32'(Valid_o), 0);
        check_eq("rst_timeout", 32'(Timeout_o), 0);
        check_eq("rst_tw", 32'(TuningWord_o), 0);
        check_eq("rst_period", 32'(Period_o), 0);
        Reset = 1'b1;

        // Tuning word 64: exact 1024-sample period
        set_dds(16'd64, 16'd0);
        pulse_start();
        check_eq("tw64_busy", 32'(Busy_o), 1);
        wait_valid(8000, got);
        check_eq("tw64_valid", 32'(got), 1);
        check_eq("tw64_tw", 32'(TuningWord_o), 64);
        check_eq("tw64_period", 32'(Period_o), 4096);
        check_eq("tw64_timeout", 32'(Timeout_o), 0);
        check_eq("tw64_busy_low", 32'(Busy_o), 0);

        // Top of the tuning range
        set_dds(16'd255, 16'd0);
        pulse_start();
        wait_valid(3000, got);
        check_eq("tw255_valid", 32'(got), 1);
        check_eq("tw255_tw", 32'(TuningWord_o), 255);
        check_eq("tw255_period", 32'(Period_o), 1028);

        // Alternating 0/255: N=8, quotient 32768 saturates; also exact latency
        @(posedge Clock);
        mode = M_CONST;
        pulse_start();
        @(posedge Clock);
        man_idx = 0;
        mode = M_MAN;
        for (int i = 0; i < 40 && man_idx != 10; i++)
            @(posedge Clock);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (Valid_o) begin
                lat = k;
                break;
            end
            @(posedge Clock);
        end
        check_eq("alt_latency", 32'(lat), 21);
        check_eq("alt_period", 32'(Period_o), 8);
        check_eq("alt_tw_sat", 32'(TuningWord_o), 255);

        // Tuning word 100 from random start phases
        for (int r = 0; r < 10; r++) begin
            set_dds(16'd100, 16'($urandom));
            pulse_start();
            wait_valid(6000, got);
            check_eq("tw100_valid", 32'(got), 1);
            check_eq("tw100_tw", 32'(TuningWord_o), 100);
            check_eq("tw100_period_ok", 32'((Period_o == 2621) || (Period_o == 2622)), 1);
        end

        // Flat midscale input: timeout after the counter reaches all-ones
        @(posedge Clock);
        mode = M_CONST;
        v0 = vcount;
        pulse_start();
        repeat ((1 << CNT_W) - 1) @(negedge Clock);
        check_eq("to_not_yet", 32'(Timeout_o), 0);
        check_eq("to_busy_before", 32'(Busy_o), 1);
        @(negedge Clock);
        check_eq("to_set", 32'(Timeout_o), 1);
        check_eq("to_busy_low", 32'(Busy_o), 0);
        check_eq("to_no_valid", 32'(vcount - v0), 0);
        check_eq("to_tw_held", 32'(TuningWord_o), 100);
        pulse_start();
        check_eq("to_cleared", 32'(Timeout_o), 0);
        check_eq("to_restart_busy", 32'(Busy_o), 1);

        // Dither inside the hysteresis band: no events, stays waiting
        @(posedge Clock);
        mode = M_DITHER;
        v0 = vcount;
        repeat (5000) @(negedge Clock);
        check_eq("dith_busy", 32'(Busy_o), 1);
        check_eq("dith_no_valid", 32'(vcount - v0), 0);
        check_eq("dith_no_timeout", 32'(Timeout_o), 0);

        // Reset asserted mid-count clears everything without a clock edge
        set_dds(16'd255, 16'd0);
        repeat (700) @(negedge Clock);
        check_eq("mid_busy", 32'(Busy_o), 1);
        #2 Reset = 1'b0;
        #1;
        check_eq("arst_busy", 32'(Busy_o), 0);
        check_eq("arst_tw", 32'(TuningWord_o), 0);
        check_eq("arst_period", 32'(Period_o), 0);
        check_eq("arst_timeout", 32'(Timeout_o), 0);
        repeat (3) @(negedge Clock);
        check_eq("arst_valid", 32'(Valid_o), 0);
        Reset = 1'b1;

        // Start pulses while busy are ignored
        set_dds(16'd255, 16'd0);
        v0 = vcount;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clock);
            Start_i = 1'b0;
            if (Valid_o) begin
                got = 1'b1;
                break;
            end
            if (Busy_o && (i % 7 == 3))
                Start_i = 1'b1;
        end
        Start_i = 1'b0;
        check_eq("ign_valid", 32'(got), 1);
        check_eq("ign_tw", 32'(TuningWord_o), 255);
        check_eq("ign_period", 32'(Period_o), 1028);
        repeat (30) @(negedge Clock);
        check_eq("ign_single_valid", 32'(vcount - v0), 1);
        check_eq("ign_idle", 32'(Busy_o), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
